alu_int_rs: RTL and testbench
=============================

# alu_int_rs

Parametrised integer-ALU reservation station for the superscalar out-of-order core. Accepts one renamed ALU µop per cycle from dispatch and holds it until both source operands are valid. Operands wake up from `NUM_CDB` common-data-bus broadcast ports, and one ready µop per cycle is issued to the ALU under a valid/ready handshake. It is the next generation of the single-port ALU RS: depth, ROB tag width and CDB port count are configurable, and it adds wakeup, select, flush and a correctly sized free-slot count.

## Interface
Parameters:
- `RS_DEPTH`, default 3: log2 of the entry count; `RS_N = 2**RS_DEPTH`.
- `ROB_DEPTH`, default 4: ROB tag width in bits.
- `NUM_CDB`, default 2: number of CDB broadcast ports.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: mispredict squash; invalidates all entries.
- `dispatch_valid` in 1: dispatch µop present.
- `dispatch_ready` out 1: RS can accept this cycle.
- `dispatch_opcode` / `dispatch_funct3` / `dispatch_funct7` in 7/3/7: operation fields.
- `dispatch_imm` in 32: immediate.
- `dispatch_rs1_v` / `dispatch_rs2_v` in 32 each: operand values, meaningful if ready.
- `dispatch_rs1_ready` / `dispatch_rs2_ready` in 1 each: operand already valid.
- `dispatch_rs1_rob` / `dispatch_rs2_rob` in `ROB_DEPTH` each: producer tag when not ready.
- `dispatch_rd` in 5: architectural destination.
- `dispatch_rob` in `ROB_DEPTH`: this µop's ROB tag.
- `cdb_valid[NUM_CDB]` in 1: broadcast valid per port.
- `cdb_rob[NUM_CDB]` in `ROB_DEPTH`: producing tag per port.
- `cdb_value[NUM_CDB]` in 32: result value per port.
- `issue_valid` out 1: a ready entry is presented.
- `issue_ready` in 1: ALU accepts.
- `issue_opcode` / `issue_funct3` / `issue_funct7` / `issue_imm` / `issue_rs1_v` / `issue_rs2_v` / `issue_rd` / `issue_rob` out, widths as at dispatch: selected entry payload.
- `free_slot_count` out `RS_DEPTH+1`: number of invalid entries, range 0..`RS_N`.

## Operation
- **Entry state:** valid, op fields, imm, rd, rob, and per operand {ready, rob tag, value}.
- **Allocation:** on `dispatch_valid && dispatch_ready`, write the lowest-index invalid entry.
- **Ready / free count:** `dispatch_ready = (free_slot_count != 0)`. Both are computed from registered valid bits only, so a slot freed by an issue this cycle is not reusable until the next cycle.
- **Wakeup:**
  - Each valid entry operand with ready=0 compares its tag against every `cdb_valid` port.
  - On a match, capture `cdb_value` and set ready=1.
  - If several ports match, the lowest port index wins.
  - Ready operands ignore the CDB.
- **Select:** `issue_valid` = some valid entry has both operands ready. The issue outputs show the lowest-index such entry. The output is combinational from registered state; the `issue_*` payload is don't-care when `issue_valid=0`.
- **Issue:** on `issue_valid && issue_ready`, the selected entry's valid bit clears at the edge. With `issue_ready=0` the same entry stays presented and the payload is held stable.
- **Simultaneous dispatch, issue and wakeup** in one cycle are all performed. A freed slot is never the allocation target in that same cycle.
- **Flush:** all valid bits clear at the edge. Flush has priority over dispatch, and issue handshakes in that cycle are dropped.

## Timing
- **Reset:** all entries invalid; `issue_valid=0`; `free_slot_count=RS_N`; `dispatch_ready=1`. Payload outputs are 0.
- **Reset mid-operation:** same as reset; in-flight µops are discarded.
- **Dispatch to issue:** dispatch with both operands ready at edge t; `issue_valid` is asserted in cycle t+1 at the earliest.
- **CDB wakeup:** broadcast in cycle t gives issue eligibility in cycle t+1.
- **Full:** with `free_slot_count=0`, `dispatch_ready=0`. A `dispatch_valid` in that cycle is not accepted and state is unchanged.
- **Empty:** `issue_valid=0`, and `issue_ready` is ignored.

## Configuration
- **`ALU_RS_DISPATCH_BYPASS_EN` defined:** a dispatching operand with ready=0 whose tag matches a same-cycle CDB broadcast is stored ready=1 with the CDB value.
- **Undefined:** dispatch fields are stored as given. Dispatch/rename must then already have forwarded any same-cycle CDB result; the RS performs no such capture.

## Test plan
- **Reset:** assert `rst` 2 cycles -> `free_slot_count=8`, `dispatch_ready=1`, `issue_valid=0`.
- **Fill:** dispatch 8 not-ready µops (tag 5) -> `free_slot_count=0`, `dispatch_ready=0`. A 9th dispatch is ignored.
- **Wakeup:** CDB port1 broadcasts rob=5, value=0xDEADBEEF -> next cycle `issue_valid=1`, entry 0 is issued with `issue_rs1_v=0xDEADBEEF`. Holding `issue_ready=0` keeps the payload stable for 3 cycles.
- **Back-to-back:** `issue_ready=1` with dispatch every cycle -> the count stays constant. After issue of entry 0, the next dispatch lands in the lowest free slot only on the following cycle.
- **Flush:** flush with 4 valid entries while `issue_valid=1` -> next cycle `free_slot_count=8`, `issue_valid=0`.
- **Bypass:** dispatch rs1 tag 3 with CDB rob=3 in the same cycle. With the macro: issued next cycle. Without the macro: no issue until a later broadcast of tag 3.

Source files
------------

// File: rtl/alu_int_rs_if.sv
// Dispatch, CDB broadcast and issue bundle of the integer-ALU reservation station.
interface alu_int_rs_if #(
    parameter int RS_DEPTH  = 3,
    parameter int ROB_DEPTH = 4,
    parameter int NUM_CDB   = 2
);
    logic                                dispatch_valid;
    logic                                dispatch_ready;
    logic [6:0]                          dispatch_opcode;
    logic [2:0]                          dispatch_funct3;
    logic [6:0]                          dispatch_funct7;
    logic [31:0]                         dispatch_imm;
    logic [31:0]                         dispatch_rs1_v;
    logic [31:0]                         dispatch_rs2_v;
    logic                                dispatch_rs1_ready;
    logic                                dispatch_rs2_ready;
    logic [ROB_DEPTH-1:0]                dispatch_rs1_rob;
    logic [ROB_DEPTH-1:0]                dispatch_rs2_rob;
    logic [4:0]                          dispatch_rd;
    logic [ROB_DEPTH-1:0]                dispatch_rob;

    logic [NUM_CDB-1:0]                  cdb_valid;
    logic [NUM_CDB-1:0][ROB_DEPTH-1:0]   cdb_rob;
    logic [NUM_CDB-1:0][31:0]            cdb_value;

    logic                                issue_valid;
    logic                                issue_ready;
    logic [6:0]                          issue_opcode;
    logic [2:0]                          issue_funct3;
    logic [6:0]                          issue_funct7;
    logic [31:0]                         issue_imm;
    logic [31:0]                         issue_rs1_v;
    logic [31:0]                         issue_rs2_v;
    logic [4:0]                          issue_rd;
    logic [ROB_DEPTH-1:0]                issue_rob;

    logic [RS_DEPTH:0]                   free_slot_count;

    modport master (
        output dispatch_valid, dispatch_opcode, dispatch_funct3, dispatch_funct7,
               dispatch_imm, dispatch_rs1_v, dispatch_rs2_v, dispatch_rs1_ready,
               dispatch_rs2_ready, dispatch_rs1_rob, dispatch_rs2_rob, dispatch_rd,
               dispatch_rob, cdb_valid, cdb_rob, cdb_value, issue_ready,
        input  dispatch_ready, issue_valid, issue_opcode, issue_funct3, issue_funct7,
               issue_imm, issue_rs1_v, issue_rs2_v, issue_rd, issue_rob, free_slot_count
    );

    modport slave (
        input  dispatch_valid, dispatch_opcode, dispatch_funct3, dispatch_funct7,
               dispatch_imm, dispatch_rs1_v, dispatch_rs2_v, dispatch_rs1_ready,
               dispatch_rs2_ready, dispatch_rs1_rob, dispatch_rs2_rob, dispatch_rd,
               dispatch_rob, cdb_valid, cdb_rob, cdb_value, issue_ready,
        output dispatch_ready, issue_valid, issue_opcode, issue_funct3, issue_funct7,
               issue_imm, issue_rs1_v, issue_rs2_v, issue_rd, issue_rob, free_slot_count
    );
endinterface

// File: rtl/alu_int_rs.sv
// Integer-ALU reservation station: CDB wakeup, lowest-index select, flush.
// Optional ALU_RS_DISPATCH_BYPASS_EN captures a same-cycle CDB result at dispatch.
module alu_int_rs #(
    parameter int RS_DEPTH  = 3,
    parameter int ROB_DEPTH = 4,
    parameter int NUM_CDB   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    alu_int_rs_if.slave rs
);
    localparam int RS_N = 2 ** RS_DEPTH;

    typedef logic [RS_DEPTH-1:0]  idx_t;
    typedef logic [RS_DEPTH:0]    cnt_t;
    typedef logic [ROB_DEPTH-1:0] tag_t;

    typedef struct packed {
        logic        rdy;
        tag_t        tag;
        logic [31:0] val;
    } opnd_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [4:0]  rd;
        tag_t        rob;
        opnd_t       src1;
        opnd_t       src2;
    } entry_t;

    // Ports are scanned high to low so the lowest matching port is written last and wins.
    function automatic opnd_t snoop(
        input opnd_t                             o,
        input logic [NUM_CDB-1:0]                vld,
        input logic [NUM_CDB-1:0][ROB_DEPTH-1:0] tag,
        input logic [NUM_CDB-1:0][31:0]          val
    );
        opnd_t r;
        r = o;
        if (!o.rdy) begin
            for (int p = NUM_CDB - 1; p >= 0; p--) begin
                if (vld[p] && (tag[p] == o.tag)) begin
                    r.rdy = 1'b1;
                    r.val = val[p];
                end
            end
        end
        return r;
    endfunction

    logic [RS_N-1:0] valid_q, valid_d;
    entry_t          ent_q [RS_N];
    entry_t          ent_d [RS_N];
    logic            hold_q, hold_d;
    idx_t            hold_idx_q, hold_idx_d;

    cnt_t            free_cnt;
    idx_t            alloc_idx;
    logic [RS_N-1:0] rdy_vec;
    idx_t            sel_idx;
    logic            any_rdy;
    logic            dready;
    logic            issue_fire;
    logic            disp_fire;
    entry_t          disp_ent;
    entry_t          sel_ent;

    always_comb begin
        free_cnt  = '0;
        alloc_idx = '0;
        for (int i = RS_N - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_cnt  = free_cnt + cnt_t'(1);
                alloc_idx = idx_t'(i);
            end
        end
    end

    always_comb begin
        rdy_vec = '0;
        for (int i = 0; i < RS_N; i++) begin
            rdy_vec[i] = valid_q[i] && ent_q[i].src1.rdy && ent_q[i].src2.rdy;
        end
    end

    // A presented-but-stalled entry stays selected even if a lower slot wakes meanwhile.
    always_comb begin
        sel_idx = '0;
        for (int i = RS_N - 1; i >= 0; i--) begin
            if (rdy_vec[i]) sel_idx = idx_t'(i);
        end
        if (hold_q) sel_idx = hold_idx_q;
    end

    assign any_rdy    = |rdy_vec;
    assign sel_ent    = ent_q[sel_idx];
    assign dready     = (free_cnt != '0);
    assign issue_fire = any_rdy && rs.issue_ready && !flush;
    assign disp_fire  = rs.dispatch_valid && dready && !flush;

    assign rs.free_slot_count = free_cnt;
    assign rs.dispatch_ready  = dready;
    assign rs.issue_valid     = any_rdy;
    assign rs.issue_opcode    = any_rdy ? sel_ent.opcode   : '0;
    assign rs.issue_funct3    = any_rdy ? sel_ent.funct3   : '0;
    assign rs.issue_funct7    = any_rdy ? sel_ent.funct7   : '0;
    assign rs.issue_imm       = any_rdy ? sel_ent.imm      : '0;
    assign rs.issue_rs1_v     = any_rdy ? sel_ent.src1.val : '0;
    assign rs.issue_rs2_v     = any_rdy ? sel_ent.src2.val : '0;
    assign rs.issue_rd        = any_rdy ? sel_ent.rd       : '0;
    assign rs.issue_rob       = any_rdy ? sel_ent.rob      : '0;

    always_comb begin
        disp_ent.opcode    = rs.dispatch_opcode;
        disp_ent.funct3    = rs.dispatch_funct3;
        disp_ent.funct7    = rs.dispatch_funct7;
        disp_ent.imm       = rs.dispatch_imm;
        disp_ent.rd        = rs.dispatch_rd;
        disp_ent.rob       = rs.dispatch_rob;
        disp_ent.src1.rdy  = rs.dispatch_rs1_ready;
        disp_ent.src1.tag  = rs.dispatch_rs1_rob;
        disp_ent.src1.val  = rs.dispatch_rs1_v;
        disp_ent.src2.rdy  = rs.dispatch_rs2_ready;
        disp_ent.src2.tag  = rs.dispatch_rs2_rob;
        disp_ent.src2.val  = rs.dispatch_rs2_v;
`ifdef ALU_RS_DISPATCH_BYPASS_EN
        disp_ent.src1 = snoop(disp_ent.src1, rs.cdb_valid, rs.cdb_rob, rs.cdb_value);
        disp_ent.src2 = snoop(disp_ent.src2, rs.cdb_valid, rs.cdb_rob, rs.cdb_value);
`endif
    end

    // Allocation uses the registered valid bits, so a slot freed by this cycle's issue is skipped.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < RS_N; i++) begin
            ent_d[i] = ent_q[i];
            if (valid_q[i]) begin
                ent_d[i].src1 = snoop(ent_q[i].src1, rs.cdb_valid, rs.cdb_rob, rs.cdb_value);
                ent_d[i].src2 = snoop(ent_q[i].src2, rs.cdb_valid, rs.cdb_rob, rs.cdb_value);
            end
        end
        if (issue_fire) valid_d[sel_idx] = 1'b0;
        if (disp_fire) begin
            valid_d[alloc_idx] = 1'b1;
            ent_d[alloc_idx]   = disp_ent;
        end
        if (flush) valid_d = '0;
        hold_d     = any_rdy && !rs.issue_ready && !flush;
        hold_idx_d = sel_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            hold_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_idx_q <= hold_idx_d;
        ent_q      <= ent_d;
    end
endmodule

// File: tb/tb_alu_int_rs.sv
// Randomized and directed bench for alu_int_rs against a slot-array reference model.
module tb_alu_int_rs;
    localparam int RSD  = 3;
    localparam int ROBD = 4;
    localparam int NCDB = 2;
    localparam int N    = 8;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    alu_int_rs_if #(.RS_DEPTH(RSD), .ROB_DEPTH(ROBD), .NUM_CDB(NCDB)) bus ();

    alu_int_rs #(.RS_DEPTH(RSD), .ROB_DEPTH(ROBD), .NUM_CDB(NCDB)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .rs    (bus)
    );

    typedef struct {
        bit        v;
        bit [6:0]  op;
        bit [2:0]  f3;
        bit [6:0]  f7;
        bit [31:0] imm;
        bit [4:0]  rd;
        bit [3:0]  rob;
        bit        r1;
        bit [3:0]  t1;
        bit [31:0] v1;
        bit        r2;
        bit [3:0]  t2;
        bit [31:0] v2;
    } ment_t;

    ment_t m [N];
    bit    m_hold;
    int    m_hold_idx;
    int    n_vec = 0;
    int    n_err = 0;
    logic [127:0] held;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_free();
        int c = 0;
        for (int i = 0; i < N; i++) if (!m[i].v) c++;
        return c;
    endfunction

    function automatic int m_sel();
        if (m_hold) return m_hold_idx;
        for (int i = 0; i < N; i++) if (m[i].v && m[i].r1 && m[i].r2) return i;
        return -1;
    endfunction

    function automatic bit cdb_hit(input bit [3:0] t, output bit [31:0] v);
        v = '0;
        for (int p = 0; p < NCDB; p++) begin
            if (bus.cdb_valid[p] && bus.cdb_rob[p] == t) begin
                v = bus.cdb_value[p];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [127:0] dut_payload();
        return {6'b0, bus.issue_opcode, bus.issue_funct3, bus.issue_funct7, bus.issue_imm,
                bus.issue_rs1_v, bus.issue_rs2_v, bus.issue_rd, bus.issue_rob};
    endfunction

    function automatic logic [127:0] m_payload(input int s);
        return {6'b0, m[s].op, m[s].f3, m[s].f7, m[s].imm, m[s].v1, m[s].v2, m[s].rd, m[s].rob};
    endfunction

    task automatic check_outputs();
        int f;
        int s;
        f = m_free();
        s = m_sel();
        chk("free_slot_count", {124'b0, bus.free_slot_count}, f);
        chk("dispatch_ready", {127'b0, bus.dispatch_ready}, {127'b0, f != 0});
        chk("issue_valid", {127'b0, bus.issue_valid}, {127'b0, s >= 0});
        if (s >= 0) chk("issue_payload", dut_payload(), m_payload(s));
    endtask

    task automatic model_update();
        int        s;
        int        a;
        bit        fire;
        bit        dfire;
        bit [31:0] cv;
        ment_t     ne;
        if (rst) begin
            for (int i = 0; i < N; i++) m[i].v = 1'b0;
            m_hold = 1'b0;
        end else begin
            s = m_sel();
            fire = (s >= 0) && bus.issue_ready && !flush;
            a = -1;
            for (int i = N - 1; i >= 0; i--) if (!m[i].v) a = i;
            dfire = bus.dispatch_valid && (a >= 0) && !flush;
            for (int i = 0; i < N; i++) begin
                if (m[i].v) begin
                    if (!m[i].r1 && cdb_hit(m[i].t1, cv)) begin m[i].r1 = 1'b1; m[i].v1 = cv; end
                    if (!m[i].r2 && cdb_hit(m[i].t2, cv)) begin m[i].r2 = 1'b1; m[i].v2 = cv; end
                end
            end
            if (fire) m[s].v = 1'b0;
            if (dfire) begin
                ne.v   = 1'b1;
                ne.op  = bus.dispatch_opcode;
                ne.f3  = bus.dispatch_funct3;
                ne.f7  = bus.dispatch_funct7;
                ne.imm = bus.dispatch_imm;
                ne.rd  = bus.dispatch_rd;
                ne.rob = bus.dispatch_rob;
                ne.r1  = bus.dispatch_rs1_ready;
                ne.t1  = bus.dispatch_rs1_rob;
                ne.v1  = bus.dispatch_rs1_v;
                ne.r2  = bus.dispatch_rs2_ready;
                ne.t2  = bus.dispatch_rs2_rob;
                ne.v2  = bus.dispatch_rs2_v;
`ifdef ALU_RS_DISPATCH_BYPASS_EN
                if (!ne.r1 && cdb_hit(ne.t1, cv)) begin ne.r1 = 1'b1; ne.v1 = cv; end
                if (!ne.r2 && cdb_hit(ne.t2, cv)) begin ne.r2 = 1'b1; ne.v2 = cv; end
`endif
                m[a] = ne;
            end
            if (flush) for (int i = 0; i < N; i++) m[i].v = 1'b0;
            m_hold     = (s >= 0) && !bus.issue_ready && !flush;
            m_hold_idx = s;
        end
    endtask

    task automatic step();
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst                    = 1'b0;
        flush                  = 1'b0;
        bus.dispatch_valid     = 1'b0;
        bus.dispatch_opcode    = '0;
        bus.dispatch_funct3    = '0;
        bus.dispatch_funct7    = '0;
        bus.dispatch_imm       = '0;
        bus.dispatch_rs1_v     = '0;
        bus.dispatch_rs2_v     = '0;
        bus.dispatch_rs1_ready = 1'b0;
        bus.dispatch_rs2_ready = 1'b0;
        bus.dispatch_rs1_rob   = '0;
        bus.dispatch_rs2_rob   = '0;
        bus.dispatch_rd        = '0;
        bus.dispatch_rob       = '0;
        bus.cdb_valid          = '0;
        bus.cdb_rob            = '0;
        bus.cdb_value          = '0;
        bus.issue_ready        = 1'b0;
    endtask

    task automatic disp(input bit [3:0] rob, input bit r1, input bit [3:0] t1, input bit [31:0] v1,
                        input bit r2, input bit [3:0] t2, input bit [31:0] v2);
        bus.dispatch_valid     = 1'b1;
        bus.dispatch_opcode    = 7'($urandom);
        bus.dispatch_funct3    = 3'($urandom);
        bus.dispatch_funct7    = 7'($urandom);
        bus.dispatch_imm       = $urandom;
        bus.dispatch_rd        = 5'($urandom);
        bus.dispatch_rob       = rob;
        bus.dispatch_rs1_ready = r1;
        bus.dispatch_rs1_rob   = t1;
        bus.dispatch_rs1_v     = v1;
        bus.dispatch_rs2_ready = r2;
        bus.dispatch_rs2_rob   = t2;
        bus.dispatch_rs2_v     = v2;
    endtask

    task automatic rand_inputs();
        idle();
        rst             = ($urandom_range(0, 299) == 0);
        flush           = ($urandom_range(0, 49) == 0);
        bus.issue_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 2) != 0)
            disp(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom);
        for (int p = 0; p < NCDB; p++) begin
            bus.cdb_valid[p] = ($urandom_range(0, 2) == 0);
            bus.cdb_rob[p]   = 4'($urandom_range(0, 7));
            bus.cdb_value[p] = $urandom;
        end
    endtask

    initial begin
        idle();
        rst    = 1'b1;
        m_hold = 1'b0;
        for (int i = 0; i < N; i++) m[i].v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_free", {124'b0, bus.free_slot_count}, 8);
        chk("rst_dready", {127'b0, bus.dispatch_ready}, 1);
        chk("rst_ivalid", {127'b0, bus.issue_valid}, 0);
        chk("rst_payload", dut_payload(), 0);

        // Fill with eight µops waiting on tag 5, then try a ninth.
        for (int i = 0; i < 8; i++) begin
            idle();
            disp(4'(i), 1'b0, 4'd5, 32'h0, 1'b1, 4'd0, $urandom);
            step();
        end
        idle();
        disp(4'd9, 1'b0, 4'd5, 32'h0, 1'b1, 4'd0, 32'h1234);
        chk("full_free", {124'b0, bus.free_slot_count}, 0);
        chk("full_dready", {127'b0, bus.dispatch_ready}, 0);
        step();
        idle();
        chk("ninth_ignored", {124'b0, bus.free_slot_count}, 0);

        // Wake all entries from CDB port 1, then stall the ALU for three cycles.
        bus.cdb_valid[1] = 1'b1;
        bus.cdb_rob[1]   = 4'd5;
        bus.cdb_value[1] = 32'hDEADBEEF;
        step();
        idle();
        chk("wake_ivalid", {127'b0, bus.issue_valid}, 1);
        chk("wake_rs1", {96'b0, bus.issue_rs1_v}, 32'hDEADBEEF);
        chk("wake_rob", {124'b0, bus.issue_rob}, 0);
        held = dut_payload();
        repeat (3) begin
            step();
            chk("hold_payload", dut_payload(), held);
        end

        // Back-to-back issue with a dispatch offered every cycle.
        for (int k = 0; k < 10; k++) begin
            idle();
            bus.issue_ready = 1'b1;
            disp(4'(k), 1'b1, 4'd0, $urandom, 1'b1, 4'd0, $urandom);
            step();
            chk("b2b_free", {124'b0, bus.free_slot_count}, 1);
        end

        // Flush with four valid entries while one is being presented.
        idle();
        rst = 1'b1;
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            idle();
            disp(4'(i), 1'b1, 4'd0, $urandom, 1'b1, 4'd0, $urandom);
            step();
        end
        idle();
        chk("pre_flush_free", {124'b0, bus.free_slot_count}, 4);
        chk("pre_flush_ivalid", {127'b0, bus.issue_valid}, 1);
        flush           = 1'b1;
        bus.issue_ready = 1'b1;
        disp(4'd7, 1'b1, 4'd0, $urandom, 1'b1, 4'd0, $urandom);
        step();
        idle();
        chk("flush_free", {124'b0, bus.free_slot_count}, 8);
        chk("flush_ivalid", {127'b0, bus.issue_valid}, 0);

        // Dispatch waiting on tag 3 while tag 3 is on the CDB.
        disp(4'd1, 1'b0, 4'd3, 32'h0, 1'b1, 4'd0, 32'h55);
        bus.cdb_valid[0] = 1'b1;
        bus.cdb_rob[0]   = 4'd3;
        bus.cdb_value[0] = 32'hCAFEF00D;
        step();
        idle();
`ifdef ALU_RS_DISPATCH_BYPASS_EN
        chk("bypass_ivalid", {127'b0, bus.issue_valid}, 1);
        chk("bypass_rs1", {96'b0, bus.issue_rs1_v}, 32'hCAFEF00D);
`else
        chk("nobypass_ivalid", {127'b0, bus.issue_valid}, 0);
        step();
        chk("nobypass_wait", {127'b0, bus.issue_valid}, 0);
        bus.cdb_valid[0] = 1'b1;
        bus.cdb_rob[0]   = 4'd3;
        bus.cdb_value[0] = 32'h0BADF00D;
        step();
        idle();
        chk("late_wake_ivalid", {127'b0, bus.issue_valid}, 1);
        chk("late_wake_rs1", {96'b0, bus.issue_rs1_v}, 32'h0BADF00D);
`endif
        bus.issue_ready = 1'b1;
        step();

        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            step();
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
